// File: rtl/udp_checksum_fifo_reader.sv
// UDP checksum FIFO reader: pops cmd_len 32-bit words, ones-complement
// sums them with a pseudo-header seed, and hands out the UDP checksum.
//
// Ports:
//   rd_clk, rd_rst           clock and async active-high reset
//   cmd_valid/ready/len/seed per-packet command handshake
//   fifo_rd_en/data/empty    FIFO read port (data valid cycle after pop)
//   csum_valid/ready, csum   checksum result handshake
//   busy                     high whenever a packet is in progress
module udp_checksum_fifo_reader #(
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [15:0]           cmd_seed,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  csum_valid,
  input  logic                  csum_ready,
  output logic [15:0]           csum,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FOLD  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE =
    {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]           state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [17:0]          acc;
  logic                 pend;

  logic [17:0] acc_next;
  logic [16:0] s1;
  logic [15:0] s2;
  logic [15:0] csum_next;

  // Pop is purely combinational so an async reset kills it at once.
  assign fifo_rd_en = (state == S_READ) && (remaining != '0)
                      && !fifo_rd_empty;
  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign csum_valid = (state == S_OUT);

  // Running sum keeps two carry bits and re-injects them each word;
  // the 18-bit width cannot overflow with three 16-bit addends + 3.
  assign acc_next = {2'b00, acc[15:0]}
                  + {16'b0, acc[17:16]}
                  + {2'b00, fifo_rd_data[31:16]}
                  + {2'b00, fifo_rd_data[15:0]};

  // Two end-around folds suffice: after the first, a carry out of
  // bit 16 leaves the low half at most 2.
  assign s1 = {1'b0, acc[15:0]} + {15'b0, acc[17:16]};
  assign s2 = s1[15:0] + {15'b0, s1[16]};

  // A computed checksum of zero is sent as all ones.
  assign csum_next = (~s2 == 16'h0000) ? 16'hFFFF : ~s2;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      csum      <= 16'h0000;
    end else begin
      pend <= fifo_rd_en;
      if (pend) acc <= acc_next;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            remaining <= cmd_len;
            acc       <= {2'b00, cmd_seed};
            state     <= (cmd_len != '0) ? S_READ : S_FOLD;
          end
        end
        S_READ: begin
          if (fifo_rd_en) begin
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= S_DRAIN;
          end
        end
        S_DRAIN: state <= S_FOLD;
        S_FOLD: begin
          csum  <= csum_next;
          state <= S_OUT;
        end
        S_OUT: begin
          if (csum_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_checksum_fifo_reader.sv
// Testbench for udp_checksum_fifo_reader: FIFO model, reference checksum
// and latency model, directed vectors plus randomized packets.
module tb_udp_checksum_fifo_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] cmd_seed = '0;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_empty = 1'b1;
  logic        csum_ready = 1'b0;
  logic        fifo_rd_en;
  logic        cmd_ready;
  logic        csum_valid;
  logic        busy;
  logic [15:0] csum;

  udp_checksum_fifo_reader #(.LEN_WIDTH(8), .DATA_WIDTH(32)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .csum_valid(csum_valid), .csum_ready(csum_ready),
    .csum(csum), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer ones-complement sum of all 16-bit halves.
  function automatic logic [15:0] ref_csum(input logic [15:0] seed,
                                           input logic [31:0] w[$]);
    longint s;
    logic [15:0] r;
    s = longint'(seed);
    foreach (w[i]) s += longint'(w[i][31:16]) + longint'(w[i][15:0]);
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    r = ~s[15:0];
    return (r == 16'h0000) ? 16'hFFFF : r;
  endfunction

  // FIFO model: no output register, data appears the cycle after a pop.
  logic [31:0] fq[$];
  int pops_total = 0;
  always @(posedge rd_clk) begin
    if (fifo_rd_en === 1'b1 && fq.size() > 0) begin
      fifo_rd_data <= fq.pop_front();
      pops_total++;
    end
  end

  // Expected-behaviour model and per-cycle compare.
  logic [15:0] exp_q[$];
  int ph = 0;
  int left = 0;
  int wt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int pk_pops = 0;
  int done_cnt = 0;
  int last_lat = 0;
  int last_pops = 0;
  bit first_v = 0;
  logic [15:0] exp_c = '0;
  logic [15:0] last_csum = '0;
  logic exp_en;

  always @(negedge rd_clk) begin
    cyc++;
    chk("pop_while_empty", {31'b0, fifo_rd_en & fifo_rd_empty}, 0);
    if (rd_rst) begin
      chk("rst_rd_en", {31'b0, fifo_rd_en}, 0);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
      chk("rst_csum_valid", {31'b0, csum_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_csum", {16'b0, csum}, 0);
      ph = 0;
    end else begin
      exp_en = (ph == 1) && !fifo_rd_empty;
      chk("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, exp_en});
      chk("cmd_ready", {31'b0, cmd_ready}, (ph == 0) ? 1 : 0);
      chk("busy", {31'b0, busy}, (ph != 0) ? 1 : 0);
      chk("csum_valid", {31'b0, csum_valid}, (ph == 3) ? 1 : 0);
      if (fifo_rd_en) pk_pops++;
      case (ph)
        0: if (cmd_valid) begin
          left    = int'(cmd_len);
          exp_c   = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
          acc_cyc = cyc;
          pk_pops = 0;
          if (cmd_len != 0) ph = 1;
          else begin ph = 2; wt = 1; end
        end
        1: if (exp_en) begin
          left--;
          if (left == 0) begin ph = 2; wt = 2; end
        end
        2: begin
          wt--;
          if (wt == 0) begin ph = 3; first_v = 1; end
        end
        3: begin
          chk("csum", {16'b0, csum}, {16'b0, exp_c});
          if (first_v) begin last_lat = cyc - acc_cyc; first_v = 0; end
          if (csum_ready) begin
            last_csum = csum;
            last_pops = pk_pops;
            done_cnt++;
            ph = 0;
          end
        end
        default: ph = 0;
      endcase
    end
  end

  // Driver: one packet from command to checksum handshake.
  // smode: 0 never stall, 1 empty every 3rd cycle, 2 random stalls.
  task automatic run_pkt(input logic [15:0] seed, input logic [31:0] w[$],
                         input int smode, input int hold);
    int d0, cc, vc;
    bit stall;
    d0 = done_cnt;
    cc = 0;
    vc = 0;
    foreach (w[i]) fq.push_back(w[i]);
    exp_q.push_back(ref_csum(seed, w));
    cmd_valid = 1'b1;
    cmd_len   = 8'(w.size());
    cmd_seed  = seed;
    fifo_rd_empty = (fq.size() == 0);
    while (done_cnt == d0 && cc < 2000) begin
      @(posedge rd_clk);
      #1;
      cmd_valid = 1'b0;
      cc++;
      case (smode)
        1: stall = (cc % 3 == 0);
        2: stall = ($urandom_range(3) == 0);
        default: stall = 0;
      endcase
      fifo_rd_empty = stall || (fq.size() == 0);
      csum_ready = csum_valid && (vc >= hold);
      if (csum_valid) vc++;
    end
    if (done_cnt == d0) chk("timeout", 0, 1);
    csum_ready = 1'b0;
  endtask

  logic [31:0] w[$];
  int p0;

  initial begin
    repeat (2) @(posedge rd_clk);
    #1 rd_rst = 1'b0;

    // Reference pins.
    w = {32'h12345678};
    chk("ref_a", {16'b0, ref_csum(16'h0, w)}, 32'h9753);
    w = {32'hFFFF0001, 32'h00000000};
    chk("ref_b", {16'b0, ref_csum(16'h0, w)}, 32'hFFFE);
    w = {32'hFFFF0000};
    chk("ref_c", {16'b0, ref_csum(16'h0, w)}, 32'hFFFF);
    w.delete();
    chk("ref_d", {16'b0, ref_csum(16'h1234, w)}, 32'hEDCB);

    w = {32'h12345678};
    run_pkt(16'h0000, w, 0, 0);
    chk("a_csum", {16'b0, last_csum}, 32'h9753);
    chk("a_pops", last_pops, 1);
    chk("a_lat", last_lat, 4);

    w = {32'hFFFF0001, 32'h00000000};
    run_pkt(16'h0000, w, 0, 0);
    chk("b_csum", {16'b0, last_csum}, 32'hFFFE);
    chk("b_lat", last_lat, 5);

    w = {32'hFFFF0000};
    run_pkt(16'h0000, w, 0, 0);
    chk("c_csum", {16'b0, last_csum}, 32'hFFFF);

    w.delete();
    run_pkt(16'h1234, w, 0, 0);
    chk("d_csum", {16'b0, last_csum}, 32'hEDCB);
    chk("d_pops", last_pops, 0);
    chk("d_lat", last_lat, 2);

    w.delete();
    repeat (255) w.push_back(32'hFFFFFFFF);
    p0 = pops_total;
    run_pkt(16'h0000, w, 1, 10);
    chk("e_csum", {16'b0, last_csum}, 32'hFFFF);
    chk("e_pops", pops_total - p0, 255);

    // Reset mid-packet after three of eight pops.
    w.delete();
    repeat (8) w.push_back($urandom);
    foreach (w[i]) fq.push_back(w[i]);
    exp_q.push_back(ref_csum(16'h0, w));
    p0 = pops_total;
    cmd_valid = 1'b1;
    cmd_len   = 8'd8;
    cmd_seed  = 16'h0;
    fifo_rd_empty = 1'b0;
    for (int k = 0; k < 50 && pops_total - p0 < 3; k++) begin
      @(posedge rd_clk);
      #1 cmd_valid = 1'b0;
    end
    chk("f_pre_pops", pops_total - p0, 3);
    rd_rst = 1'b1;
    #1;
    chk("f_rd_en_async", {31'b0, fifo_rd_en}, 0);
    chk("f_cmd_ready", {31'b0, cmd_ready}, 1);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    fq.delete();
    exp_q.delete();
    fifo_rd_empty = 1'b1;
    w = {32'h00010002};
    run_pkt(16'h0000, w, 0, 0);
    chk("f_csum", {16'b0, last_csum}, 32'hFFFC);

    // Randomized packets.
    for (int n = 0; n < 40; n++) begin
      int len;
      len = (n % 10 == 9) ? $urandom_range(255, 100) : $urandom_range(20);
      w.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(3))
          0: w.push_back(32'hFFFFFFFF);
          1: w.push_back(32'hFFFF0000);
          default: w.push_back($urandom);
        endcase
      end
      p0 = pops_total;
      run_pkt(16'($urandom), w, $urandom_range(2), $urandom_range(4));
      chk("r_pops", pops_total - p0, len);
    end

    repeat (3) @(posedge rd_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
